// File: rtl/wb_pkg.sv
// Shared constants and entry type for the write-back stage buffer.
package wb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;
  localparam int DEPTH_DEF  = 2;
  localparam int RETIRE_W   = 32;

  // One buffered register-file write at the default widths.
  typedef struct packed {
    logic [REG_AW_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order {rd, data} buffer for the write-back stage.
// With WB_FWD_EN defined, the entries are also presented oldest-first
// (index 0 = head) with a valid mask, for the forwarding search.
// Flush has priority over push and pop in its cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] wr_rd_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [REG_AW-1:0] head_rd_o,
  output logic [DATA_W-1:0] head_data_o
`ifdef WB_FWD_EN
  ,
  output logic [REG_AW-1:0] age_rd_o   [DEPTH],
  output logic [DATA_W-1:0] age_data_o [DEPTH],
  output logic [DEPTH-1:0]  age_valid_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Head entry drives the write port; zero while empty.
  assign head_rd_o   = empty_o ? '0 : rd_mem[rd_ptr_q];
  assign head_data_o = empty_o ? '0 : data_mem[rd_ptr_q];

  // Next pointers and occupancy; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr_q]   <= wr_rd_i;
      data_mem[wr_ptr_q] <= wr_data_i;
    end
  end

`ifdef WB_FWD_EN
  // Oldest-first view of the buffer for the forwarding search.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign age_rd_o[k]    = rd_mem[rd_ptr_q + PW'(k)];
    assign age_data_o[k]  = data_mem[rd_ptr_q + PW'(k)];
    assign age_valid_o[k] = (CW'(k) < count_q);
  end
`endif

endmodule

// File: rtl/wb_stage_buf.sv
// Write-back stage: filters no-effect beats, buffers the rest in order,
// drains them to the register-file port and counts retirements.
// Optional macro WB_FWD_EN adds combinational operand forwarding from
// the buffered entries.
//
// Handshakes: a beat transfers on a cycle where valid and ready are both
// high at the rising edge (in_valid/in_ready upstream, rf_we/rf_ready
// downstream). in_ready depends on buffer state only, never on rf_ready.
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int R0_HARDWIRED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_reg_write,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic [DATA_W-1:0]   in_result,
  input  logic                flush,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic                rf_ready,
  output logic [RETIRE_W-1:0] retire_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [REG_AW-1:0]   fwd_rs_a,
  input  logic [REG_AW-1:0]   fwd_rs_b,
  output logic                fwd_hit_a,
  output logic                fwd_hit_b,
  output logic [DATA_W-1:0]   fwd_data_a,
  output logic [DATA_W-1:0]   fwd_data_b
`endif
);

  logic                fifo_full, fifo_empty;
  logic                accept, no_effect, discard, push, pop;
  logic [RETIRE_W-1:0] retire_q, retire_d;

`ifdef WB_FWD_EN
  logic [REG_AW-1:0] age_rd   [DEPTH];
  logic [DATA_W-1:0] age_data [DEPTH];
  logic [DEPTH-1:0]  age_valid;
`endif

  assign in_ready  = !fifo_full;
  assign rf_we     = !fifo_empty;
  assign accept    = in_valid && in_ready;
  // Beats that change no architectural register never enter the buffer.
  assign no_effect = !in_reg_write || ((R0_HARDWIRED != 0) && (in_rd == '0));
  assign discard   = accept && no_effect && !flush;
  assign push      = accept && !no_effect;
  assign pop       = rf_we && rf_ready && !flush;

  wb_fifo #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .wr_rd_i     (in_rd),
    .wr_data_i   (in_result),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_rd_o   (rf_waddr),
    .head_data_o (rf_wdata)
`ifdef WB_FWD_EN
    ,
    .age_rd_o    (age_rd),
    .age_data_o  (age_data),
    .age_valid_o (age_valid)
`endif
  );

  // Retire count: +1 per pop, +1 per discarded beat; nothing on flush.
  always_comb begin
    retire_d = retire_q;
    if (!flush) begin
      retire_d = retire_q + RETIRE_W'(pop) + RETIRE_W'(discard);
    end
  end

  // Retire counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;

`ifdef WB_FWD_EN
  // Lookup A: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (age_rd[k] == fwd_rs_a)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = age_data[k];
      end
    end
    if ((R0_HARDWIRED != 0) && (fwd_rs_a == '0)) begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
    end
  end

  // Lookup B: same search for the second operand.
  always_comb begin
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (age_rd[k] == fwd_rs_b)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = age_data[k];
      end
    end
    if ((R0_HARDWIRED != 0) && (fwd_rs_b == '0)) begin
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf at default parameters (DEPTH=2, R0 hardwired).
// Reference model: a queue of pending writes plus a retire count.
module tb_wb_stage_buf;
  import wb_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int DEP = 2;
  localparam int EW  = $bits(wb_entry_t);

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_reg_write = 1'b0, flush = 1'b0, rf_ready = 1'b0;
  logic [AW-1:0] in_rd = '0;
  logic [DW-1:0] in_result = '0;
  logic          in_ready, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   retire_cnt;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_rs_a = '0, fwd_rs_b = '0;
  logic          fwd_hit_a, fwd_hit_b;
  logic [DW-1:0] fwd_data_a, fwd_data_b;
`endif

  wb_stage_buf dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_write (in_reg_write),
    .in_rd        (in_rd),
    .in_result    (in_result),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_ready     (rf_ready),
    .retire_cnt   (retire_cnt)
`ifdef WB_FWD_EN
    ,
    .fwd_rs_a     (fwd_rs_a),
    .fwd_rs_b     (fwd_rs_b),
    .fwd_hit_a    (fwd_hit_a),
    .fwd_hit_b    (fwd_hit_b),
    .fwd_data_a   (fwd_data_a),
    .fwd_data_b   (fwd_data_b)
`endif
  );

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_cnt;
  int total = 0;
  int bad   = 0;

  // Driver: apply one cycle of inputs and advance the model at the edge.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] rd,
                       input logic [DW-1:0] d, input logic fl, input logic rr);
    logic was_full;
    in_valid = v; in_reg_write = we; in_rd = rd; in_result = d;
    flush = fl; rf_ready = rr;
    was_full = (exp_q.size() >= DEP);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && rr) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (v && !was_full) begin
        if (!we || rd == 0) m_cnt++;
        else exp_q.push_back({rd, d});
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  // Driver: synchronise a reset pulse and clear the model.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; rf_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_cnt = '0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL por_in_ready got=%b want=1", in_ready); end
    total++; if (rf_we !== 1'b0)     begin bad++; $display("FAIL por_rf_we got=%b want=0", rf_we); end
    total++; if (rf_waddr !== '0)    begin bad++; $display("FAIL por_waddr got=%0d want=0", rf_waddr); end
    total++; if (rf_wdata !== '0)    begin bad++; $display("FAIL por_wdata got=%h want=0", rf_wdata); end
    total++; if (retire_cnt !== '0)  begin bad++; $display("FAIL por_retire got=%0d want=0", retire_cnt); end
`ifdef WB_FWD_EN
    total++; if (fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin bad++; $display("FAIL por_fwd_hit got=%b%b want=00", fwd_hit_a, fwd_hit_b); end
`endif
    do_reset();
    // one discard then two buffered entries, then reset mid-cycle
    cycle(1'b1, 1'b0, 3'd4, 16'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd1, 16'haaaa, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd2, 16'hbbbb, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0 || retire_cnt !== 32'd1) begin bad++; $display("FAIL rst_setup ready=%b cnt=%0d want ready=0 cnt=1", in_ready, retire_cnt); end
    #2 rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (rf_we !== 1'b0)      begin bad++; $display("FAIL rst_rf_we got=%b want=0", rf_we); end
    total++; if (retire_cnt !== '0)   begin bad++; $display("FAIL rst_retire got=%0d want=0", retire_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_cnt = '0;
  endtask

  task automatic test_single_write();
    do_reset();
    cycle(1'b1, 1'b1, 3'd5, 16'h1234, 1'b0, 1'b1);
    total++; if (rf_we !== 1'b1)        begin bad++; $display("FAIL single_we got=%b want=1", rf_we); end
    total++; if (rf_waddr !== 3'd5)     begin bad++; $display("FAIL single_waddr got=%0d want=5", rf_waddr); end
    total++; if (rf_wdata !== 16'h1234) begin bad++; $display("FAIL single_wdata got=%h want=1234", rf_wdata); end
    total++; if (retire_cnt !== 32'd0)  begin bad++; $display("FAIL single_cnt0 got=%0d want=0", retire_cnt); end
    cycle(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    total++; if (retire_cnt !== 32'd1)  begin bad++; $display("FAIL single_cnt1 got=%0d want=1", retire_cnt); end
    total++; if (rf_we !== 1'b0)        begin bad++; $display("FAIL single_drained got=%b want=0", rf_we); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    cycle(1'b1, 1'b1, 3'd1, 16'h0101, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want=1", in_ready); end
    cycle(1'b1, 1'b1, 3'd2, 16'h0202, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
    cycle(1'b1, 1'b1, 3'd3, 16'h0303, 1'b0, 1'b0);
    total++; if (in_ready !== 1'b0 || rf_waddr !== 3'd1) begin bad++; $display("FAIL bp_hold ready=%b waddr=%0d want ready=0 waddr=1", in_ready, rf_waddr); end
    // full with a pop: rd=3 is not taken this cycle
    cycle(1'b1, 1'b1, 3'd3, 16'h0303, 1'b0, 1'b1);
    total++; if (rf_waddr !== 3'd2 || rf_wdata !== 16'h0202 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_w2 waddr=%0d wdata=%h ready=%b want 2/0202/1", rf_waddr, rf_wdata, in_ready); end
    cycle(1'b1, 1'b1, 3'd3, 16'h0303, 1'b0, 1'b1);
    total++; if (rf_waddr !== 3'd3 || rf_wdata !== 16'h0303) begin bad++; $display("FAIL bp_w3 waddr=%0d wdata=%h want 3/0303", rf_waddr, rf_wdata); end
    cycle(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    total++; if (retire_cnt !== 32'd3 || rf_we !== 1'b0) begin bad++; $display("FAIL bp_done cnt=%0d we=%b want cnt=3 we=0", retire_cnt, rf_we); end
  endtask

  task automatic test_discard();
    do_reset();
    cycle(1'b1, 1'b0, 3'd4, 16'hdead, 1'b0, 1'b1);
    total++; if (rf_we !== 1'b0 || retire_cnt !== 32'd1) begin bad++; $display("FAIL disc_nowrite we=%b cnt=%0d want we=0 cnt=1", rf_we, retire_cnt); end
    cycle(1'b1, 1'b1, 3'd0, 16'hbeef, 1'b0, 1'b1);
    total++; if (rf_we !== 1'b0 || retire_cnt !== 32'd2) begin bad++; $display("FAIL disc_r0 we=%b cnt=%0d want we=0 cnt=2", rf_we, retire_cnt); end
    // pop and discard together give +2
    cycle(1'b1, 1'b1, 3'd6, 16'h0006, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 3'd1, 16'h0000, 1'b0, 1'b1);
    total++; if (retire_cnt !== 32'd4 || rf_we !== 1'b0) begin bad++; $display("FAIL disc_plus2 cnt=%0d we=%b want cnt=4 we=0", retire_cnt, rf_we); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd6, 16'h6666, 1'b1, 1'b1);
    total++; if (rf_we !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_empty we=%b ready=%b want we=0 ready=1", rf_we, in_ready); end
    total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL flush_cnt got=%0d want=0", retire_cnt); end
    // discard offered during flush is not counted either
    cycle(1'b1, 1'b0, 3'd2, 16'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    total++; if (retire_cnt !== 32'd0 || rf_we !== 1'b0) begin bad++; $display("FAIL flush_after cnt=%0d we=%b want cnt=0 we=0", retire_cnt, rf_we); end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forwarding();
    do_reset();
    cycle(1'b1, 1'b1, 3'd3, 16'h0011, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 3'd3, 16'h0022, 1'b0, 1'b0);
    fwd_rs_a = 3'd3; fwd_rs_b = 3'd0;
    #1;
    total++; if (fwd_hit_a !== 1'b1 || fwd_data_a !== 16'h0022) begin bad++; $display("FAIL fwd_young hit=%b data=%h want 1/0022", fwd_hit_a, fwd_data_a); end
    total++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== 16'h0) begin bad++; $display("FAIL fwd_r0 hit=%b data=%h want 0/0000", fwd_hit_b, fwd_data_b); end
    fwd_rs_b = 3'd5;
    #1;
    total++; if (fwd_hit_b !== 1'b0 || fwd_data_b !== 16'h0) begin bad++; $display("FAIL fwd_miss hit=%b data=%h want 0/0000", fwd_hit_b, fwd_data_b); end
  endtask
`endif

  task automatic test_random();
    wb_entry_t   e;
    logic        exp_hit;
    logic [DW-1:0] exp_data;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
            AW'($urandom_range(0, 7)), DW'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
      total++; if (in_ready !== (exp_q.size() < DEP)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, in_ready, exp_q.size() < DEP); end
      total++; if (rf_we !== (exp_q.size() > 0)) begin bad++; $display("FAIL rnd_we n=%0d got=%b want=%b", n, rf_we, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        e = wb_entry_t'(exp_q[0]);
        total++; if (rf_waddr !== e.rd || rf_wdata !== e.data) begin bad++; $display("FAIL rnd_head n=%0d got=%0d/%h want=%0d/%h", n, rf_waddr, rf_wdata, e.rd, e.data); end
      end
      total++; if (retire_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, retire_cnt, m_cnt); end
`ifdef WB_FWD_EN
      fwd_rs_a = AW'($urandom_range(0, 7));
      #1;
      exp_hit = 1'b0; exp_data = '0;
      if (fwd_rs_a != 0) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          e = wb_entry_t'(exp_q[i]);
          if (!exp_hit && e.rd == fwd_rs_a) begin exp_hit = 1'b1; exp_data = e.data; end
        end
      end
      total++; if (fwd_hit_a !== exp_hit || fwd_data_a !== exp_data) begin bad++; $display("FAIL rnd_fwd n=%0d rs=%0d got=%b/%h want=%b/%h", n, fwd_rs_a, fwd_hit_a, fwd_data_a, exp_hit, exp_data); end
`endif
    end
  endtask

  // Sequence and final report
  initial begin
    m_cnt = '0;
    test_reset();
    test_single_write();
    test_back_pressure();
    test_discard();
    test_flush();
`ifdef WB_FWD_EN
    test_forwarding();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage_buf.md
# wb_stage_buf

Parametrised write-back stage for the pipelined processor. It accepts results from the execute/memory stage over a valid/ready handshake and holds them in a small in-order buffer. It drains them to the register-file write port, which can apply back-pressure. It suppresses writes that have no architectural effect, keeps a retirement counter and optionally exposes buffered results for operand forwarding.

## Interface
Parameters:
- DATA_W, 16, result / register data width
- REG_AW, 3, register address width
- DEPTH, 2, buffer entries; power of two, ≥2
- R0_HARDWIRED, 1, when 1 register 0 is read-only zero and writes to it are discarded

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_reg_write  input  1  beat writes a register
- in_rd  input  REG_AW  destination register
- in_result  input  DATA_W  result data
- flush  input  1  synchronous discard of all buffered entries
- rf_we  output  1  register-file write request
- rf_waddr  output  REG_AW  write address
- rf_wdata  output  DATA_W  write data
- rf_ready  input  1  register file accepts the write this cycle
- retire_cnt  output  32  retired-instruction count
- fwd_rs_a, fwd_rs_b  input  REG_AW  forwarding lookup addresses (WB_FWD_EN only)
- fwd_hit_a, fwd_hit_b  output  1  lookup matched a buffered entry (WB_FWD_EN only)
- fwd_data_a, fwd_data_b  output  DATA_W  matched data (WB_FWD_EN only)

## Operation
- In-order FIFO of DEPTH entries {rd, data}, with an occupancy counter 0..DEPTH and wrapping read/write pointers of log2(DEPTH) bits.
- in_ready = !full. It is registered-state only and has no combinational path from rf_ready.
- Accept occurs when in_valid && in_ready.
  - A beat with in_reg_write=0, or with in_rd=0 while R0_HARDWIRED=1, is discarded at the input. It is not queued and counts as retired that cycle.
  - Any other beat is pushed.
- rf_we = !empty. rf_waddr and rf_wdata are taken from the head entry.
- Pop occurs when rf_we && rf_ready. A push and a pop in the same cycle leave occupancy unchanged.
- When the buffer is full, no push occurs even if a pop happens that cycle.
- retire_cnt increments by 1 for each pop and by 1 for each discarded beat. Both can occur in one cycle, giving +2. The counter wraps modulo 2^32.
- flush has priority over everything in its cycle:
  - occupancy goes to 0 and pointers reset;
  - the incoming beat is dropped and not counted;
  - a pending pop is not counted, even if rf_ready=1.
- Write ordering to the register file equals accept order.

## Timing
- Reset values: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, retire_cnt=0, fwd_hit_*=0. Buffer is empty.
- Asserting rst mid-operation drops all entries immediately; no write completes.
- Latency: a beat accepted at edge N into an empty buffer drives rf_we=1 in the cycle after edge N. This is one cycle, the same as the previous non-buffered stage.
- Throughput: one write per cycle while rf_ready=1.
- retire_cnt updates at the edge of the pop or discard.
- Forwarding outputs are combinational from stored entries and fwd_rs_*, with no latency.

## Configuration
- WB_FWD_EN defined:
  - fwd_* ports exist;
  - each lookup searches valid entries youngest-to-oldest for rd == fwd_rs;
  - hit=1 returns the youngest match's data;
  - rs=0 with R0_HARDWIRED=1 never hits;
  - on no hit, data=0.
- WB_FWD_EN undefined: fwd_* ports and the search logic are absent. All other behaviour is identical.

## Structure
- Package wb_pkg holds:
  - default DATA_W/REG_AW/DEPTH constants;
  - the typedef wb_entry_t {rd, data};
  - the retire counter width constant (32).
- Sub-module wb_fifo holds the storage array, pointers, occupancy, and full/empty/flush logic, and exposes its entries for the forwarding search. The top level holds the discard filter, retire counter and forwarding mux.

## Test plan
- Reset: assert rst with 2 entries buffered -> in_ready=1, rf_we=0, retire_cnt=0 immediately.
- Single write: rd=5, result=0x1234, reg_write=1, rf_ready=1 -> next cycle rf_we=1, waddr=5, wdata=0x1234; retire_cnt=1 after that edge.
- Back-pressure: rf_ready=0, offer rd=1/2/3 (DEPTH=2) -> in_ready=0 after two accepts. Then rf_ready=1 -> writes 1, 2, 3 in order; retire_cnt=3.
- Discard: reg_write=0 beat, then rd=0 beat with reg_write=1 -> rf_we stays 0, retire_cnt=2.
- Flush: 2 entries buffered, flush=1 with in_valid=1 and rf_ready=1 -> empty, no write, retire_cnt unchanged, in_ready=1.
- Forwarding (WB_FWD_EN, rf_ready=0): push rd=3/0x0011 then rd=3/0x0022. Query fwd_rs_a=3 -> hit=1, data=0x0022. Query fwd_rs_b=0 -> hit=0.
